// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states,
// instruction size and the fetch-queue entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FAULT
    } state_t;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two depth, synchronous flush,
// push and pop may both take effect in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with redirect draining and a fetch queue.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        state_d;
    logic [63:0]   req_pc;
    logic [63:0]   req_pc_d;
    logic [63:0]   rsp_pc;
    logic [63:0]   rsp_pc_d;
    logic [63:0]   target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic          fire;
    logic          push;
    logic          pop;
    logic          flush;
    logic          empty;
    logic          misaligned;
    entry_t        push_data;
    entry_t        head;

    assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && (state == RUN)
                            && (inflight < (CW+1)'(DEPTH));
    assign imem_addr = reset ? RESET_PC : req_pc;
    assign fire      = imem_req_valid && imem_req_ready;
    assign if_valid  = !reset && !empty;
    assign pop       = if_valid && id_ready;
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign push_data = '{instr: imem_rsp_data, pc: rsp_pc};
    assign target    = {redirect_pc[63:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned  = |redirect_pc[1:0];
    assign fetch_fault = (state == FAULT);
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign misaligned     = 1'b0;
    assign fetch_fault    = 1'b0;
`endif

    // Responses always retire a request, whether kept or discarded.
    always_comb begin
        out_d = outstanding;
        if (fire && !imem_rsp_valid)
            out_d = outstanding + 1'b1;
        else if (!fire && imem_rsp_valid)
            out_d = outstanding - 1'b1;
    end

    always_comb begin
        state_d  = state;
        req_pc_d = req_pc;
        rsp_pc_d = rsp_pc;
        push     = 1'b0;
        flush    = 1'b0;
        if (redirect_valid) begin
            flush    = 1'b1;
            req_pc_d = target;
            rsp_pc_d = target;
            if (misaligned)
                state_d = FAULT;
            else if (out_d != '0)
                state_d = DRAIN;
            else
                state_d = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (fire)
                        req_pc_d = req_pc + 64'(INSTR_BYTES);
                    if (imem_rsp_valid) begin
                        push     = 1'b1;
                        rsp_pc_d = rsp_pc + 64'(INSTR_BYTES);
                    end
                end
                DRAIN: begin
                    if (out_d == '0)
                        state_d = RUN;
                end
                FAULT: state_d = FAULT;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_d;
            req_pc      <= req_pc_d;
            rsp_pc      <= rsp_pc_d;
            outstanding <= out_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency memory model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    fetch_unit #(
        .RESET_PC(64'h0),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .id_ready      (id_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] dpc[$];
    logic [31:0] dins[$];
    int          cyc;
    int          lat;
    int          n_cmp;
    int          n_err;
    int          n_fire;
    int          nd;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        f;
        logic [63:0] fa;
        #1;
        f  = imem_req_valid && imem_req_ready;
        fa = imem_addr;
        if (if_valid && id_ready) begin
            dpc.push_back(if_pc);
            dins.push_back(if_instr);
        end
        if (imem_rsp_valid && pend.size() > 0)
            void'(pend.pop_front());
        @(posedge clk);
        #1;
        cyc++;
        if (f) begin
            n_fire++;
            pend.push_back('{due: cyc - 1 + lat, addr: fa});
        end
        redirect_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend.delete();
        tick();
        tick();
        pend.delete();
        dpc.delete();
        dins.delete();
        imem_rsp_valid = 1'b0;
        n_fire = 0;
        reset  = 1'b0;
        cyc    = 0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_fire = 0;
        cyc = 0;
        lat = 1;
        reset = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_addr", imem_addr, 64'h0);

        // Streaming at latency 1
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        chk("rst_fault", fetch_fault, 0);
        chk("c0_req_valid", imem_req_valid, 1);
        chk("c0_addr", imem_addr, 64'h0);
        tick();
        chk("c1_addr", imem_addr, 64'h4);
        chk("c1_if_valid", if_valid, 0);
        tick();
        chk("c2_if_valid", if_valid, 1);
        chk("c2_if_pc", if_pc, 64'h0);
        chk("c2_if_instr", if_instr, word(64'h0));
        tick();
        chk("c3_if_pc", if_pc, 64'h4);
        chk("c3_if_instr", if_instr, word(64'h4));
        tick();
        chk("c4_if_pc", if_pc, 64'h8);
        chk("c4_if_instr", if_instr, word(64'h8));

        // Decode stalled: queue fills to DEPTH
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        id_ready = 1'b0;
        repeat (10) tick();
        chk("stall_fires", n_fire, DEPTH);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_if_pc", if_pc, 64'h0);
        id_ready = 1'b1;
        for (int i = 0; i < 20 && dpc.size() < 4; i++) tick();
        chk("stall_ndeliv", dpc.size() >= 4, 1);
        chk("stall_pc0", dpc[0], 64'h0);
        chk("stall_pc1", dpc[1], 64'h4);
        chk("stall_pc2", dpc[2], 64'h8);
        chk("stall_pc3", dpc[3], 64'hC);
        chk("stall_ins3", dins[3], word(64'hC));

        // Latency 3, redirect with two outstanding
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h1000;
        tick();
        imem_req_ready = 1'b1;
        nd = 0;
        while (!imem_req_valid && nd < 20) begin
            tick();
            nd++;
        end
        chk("rd3_fires", n_fire, 2);
        chk("rd3_drain_cycles", nd, 2);
        chk("rd3_addr", imem_addr, 64'h1000);
        for (int i = 0; i < 20 && dpc.size() < 1; i++) tick();
        chk("rd3_first_pc", dpc[0], 64'h1000);
        chk("rd3_first_ins", dins[0], word(64'h1000));

        // Redirect coinciding with fire and response
        do_reset();
        lat = 2;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        tick();
        tick();
        chk("rdc_rsp_here", imem_rsp_valid, 1);
        chk("rdc_req_here", imem_req_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        tick();
        nd = 0;
        while (!imem_req_valid && nd < 20) begin
            tick();
            nd++;
        end
        chk("rdc_drain_cycles", nd, 2);
        chk("rdc_pend_empty", pend.size(), 0);
        chk("rdc_addr", imem_addr, 64'h2000);
        for (int i = 0; i < 20 && dpc.size() < 1; i++) tick();
        chk("rdc_first_pc", dpc[0], 64'h2000);

        // Redirect latency and alignment handling
        do_reset();
        lat = 1;
        imem_req_ready = 1'b0;
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h300;
        tick();
        chk("lat_req_valid", imem_req_valid, 1);
        chk("lat_addr", imem_addr, 64'h300);
        redirect_valid = 1'b1;
        redirect_pc = 64'h1002;
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", fetch_fault, 1);
        chk("mis_req_valid", imem_req_valid, 0);
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk("mis_hold_fault", fetch_fault, 1);
        chk("mis_hold_req", imem_req_valid, 0);
        chk("mis_no_fire", n_fire, 0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        tick();
        chk("fix_fault", fetch_fault, 0);
        chk("fix_req_valid", imem_req_valid, 1);
        chk("fix_addr", imem_addr, 64'h2000);
        for (int i = 0; i < 20 && dpc.size() < 1; i++) tick();
        chk("fix_first_pc", dpc[0], 64'h2000);
`else
        chk("mis_fault", fetch_fault, 0);
        chk("mis_req_valid", imem_req_valid, 1);
        chk("mis_addr", imem_addr, 64'h1000);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && dpc.size() < 1; i++) tick();
        chk("mis_first_pc", dpc[0], 64'h1000);
        chk("mis_first_ins", dins[0], word(64'h1000));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 64'h0, first fetch address after reset.
REQ-002 Parameter DEPTH, 4, fetch-queue entries; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request; fire = valid && ready.
REQ-007 imem_addr  output  64  request byte address, [1:0]=00.
REQ-008 imem_rsp_valid  input  1  instruction word returned, in request order, latency >=1, no backpressure.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 if_valid  output  1  instruction available to decode/immediate stage.
REQ-011 id_ready  input  1  decode accepts; pop = if_valid && id_ready.
REQ-012 if_instr  output  32  instruction word at queue head.
REQ-013 if_pc  output  64  byte address of if_instr.
REQ-014 redirect_valid  input  1  branch/jump redirect, one-cycle pulse.
REQ-015 redirect_pc  input  64  redirect target.
REQ-016 fetch_fault  output  1  misaligned redirect target (see Configuration).

Function
REQ-017 SHALL hold a request PC (req_pc), a response PC (rsp_pc), an outstanding counter (0..DEPTH) and a DEPTH-entry FIFO of {instr, pc}.
REQ-018 SHALL assert imem_req_valid only in state RUN and when outstanding + fifo_count < DEPTH; imem_addr = req_pc.
REQ-019 On request fire, SHALL increment req_pc by 4 (64-bit wrap) and outstanding by 1.
REQ-020 On imem_rsp_valid in RUN, SHALL push {imem_rsp_data, rsp_pc}, increment rsp_pc by 4, and decrement outstanding; simultaneous fire and response leave outstanding unchanged.
REQ-021 SHALL drive if_valid = FIFO not empty, if_instr/if_pc from the head; pop on handshake; push and pop in the same cycle SHALL both take effect.
REQ-022 FSM states RUN, DRAIN, FAULT; reset enters RUN.
REQ-023 On redirect_valid: flush FIFO, req_pc <= rsp_pc <= redirect_pc; every outstanding request, including one firing this cycle, becomes stale; next state DRAIN if stale count > 0, else RUN.
REQ-024 DRAIN: no requests; responses discarded, never pushed; exit to RUN the cycle after outstanding reaches 0.
REQ-025 A redirect during DRAIN SHALL update req_pc/rsp_pc and remain in DRAIN.
REQ-026 A pop in the redirect cycle completes normally; a response in the redirect cycle is discarded.
REQ-027 Redirect SHALL take priority over all other same-cycle updates.
REQ-028 Latency: redirect at cycle N with nothing outstanding -> imem_req_valid at N+1 with imem_addr = redirect_pc.

Reset
REQ-029 Reset SHALL set req_pc = rsp_pc = RESET_PC, outstanding = 0, FIFO empty, state RUN, fetch_fault = 0.
REQ-030 Outputs in reset cycle: imem_req_valid = 0, if_valid = 0, imem_addr = RESET_PC; first request in the cycle after reset deasserts.
REQ-031 Reset mid-DRAIN SHALL abandon stale tracking; memory is reset alongside.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 00 flushes as REQ-023, enters FAULT, asserts fetch_fault from next cycle; FAULT issues no requests, discards responses, and is left only by an aligned redirect (to DRAIN/RUN per REQ-023, fetch_fault cleared).
REQ-033 Macro undefined: redirect_pc[1:0] ignored (treated as 00), fetch_fault tied 0, FAULT unreachable.

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enum, INSTR_BYTES = 4, and the {instr, pc} entry struct.
REQ-035 Sub-module fetch_fifo (parameterised depth, synchronous flush, simultaneous push/pop) SHALL implement the queue.

Verification
REQ-036 Reset release, memory latency 1, id_ready=1 -> if_pc sequence 0x0, 0x4, 0x8 with matching words, one per cycle.
REQ-037 id_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then imem_req_valid held 0; queue drains in order when released.
REQ-038 Latency 3, redirect to 0x1000 with 2 outstanding -> 2 responses discarded, DRAIN 2 cycles, first delivered if_pc = 0x1000.
REQ-039 Redirect coinciding with request fire and response -> both stale, nothing delivered from old stream, outstanding reaches 0 before new fetch.
REQ-040 With FETCH_ALIGN_CHECK_EN: redirect to 0x1002 -> fetch_fault=1, no requests; redirect to 0x2000 -> fault clears, fetch resumes at 0x2000; without macro: 0x1002 fetches 0x1000.
